// File: rtl/wireframe_pkg.sv
// Shared types and constants for the wireframe edge sequencer and its geometry tables.
package wireframe_pkg;

  localparam int DEF_MAX_VERTS = 16;
  localparam int DEF_MAX_EDGES = 32;

  localparam logic CFG_SEL_VERT = 1'b0;
  localparam logic CFG_SEL_EDGE = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    CHECK,
    ISSUE,
    WAIT_DONE,
    REARM,
    FINISH
  } seq_state_t;

  typedef struct packed {
    logic [7:0] x;
    logic [7:0] y;
  } vertex_t;

  // Vertex indices sit in the low bits of each byte; unused upper bits are kept as written.
  typedef struct packed {
    logic [7:0] va;
    logic [7:0] vb;
  } edge_t;

endpackage

// File: rtl/wireframe_geom_ram.sv
// Vertex and edge tables: one write port, registered edge read followed by a registered dual vertex read.
module wireframe_geom_ram
  import wireframe_pkg::*;
#(
  parameter int MAX_VERTS = DEF_MAX_VERTS,
  parameter int MAX_EDGES = DEF_MAX_EDGES,
  localparam int VIDX_W = $clog2(MAX_VERTS),
  localparam int EIDX_W = $clog2(MAX_EDGES)
) (
  input  logic              clk,
  input  logic              vert_we,
  input  logic              edge_we,
  input  logic [EIDX_W-1:0] waddr,
  input  logic [15:0]       wdata,
  input  logic [EIDX_W-1:0] edge_raddr,
  output logic [15:0]       edge_rd,
  output logic [15:0]       vert_a_rd,
  output logic [15:0]       vert_b_rd
);

  vertex_t vert_tab [MAX_VERTS];
  edge_t   edge_tab [MAX_EDGES];

  edge_t   edge_p0;
  vertex_t va_p1;
  vertex_t vb_p1;

  always_ff @(posedge clk) begin
    if (vert_we) vert_tab[waddr[VIDX_W-1:0]] <= vertex_t'(wdata);
    if (edge_we) edge_tab[waddr] <= edge_t'(wdata);
    // stage p0: edge entry; stage p1: both endpoints addressed by the p0 entry
    edge_p0 <= edge_tab[edge_raddr];
    va_p1   <= vert_tab[edge_p0.va[VIDX_W-1:0]];
    vb_p1   <= vert_tab[edge_p0.vb[VIDX_W-1:0]];
  end

  assign edge_rd   = edge_p0;
  assign vert_a_rd = va_p1;
  assign vert_b_rd = vb_p1;

endmodule

// File: rtl/wireframe_edge_sequencer.sv
// Walks the edge table and hands one segment at a time to the line drawer.
// Optional watchdog in WAIT_DONE enabled by defining SEQ_TIMEOUT_EN.
module wireframe_edge_sequencer
  import wireframe_pkg::*;
#(
  parameter int MAX_VERTS      = DEF_MAX_VERTS,
  parameter int MAX_EDGES      = DEF_MAX_EDGES,
  parameter int TIMEOUT_CYCLES = 65535,
  localparam int VIDX_W = $clog2(MAX_VERTS),
  localparam int EIDX_W = $clog2(MAX_EDGES)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_we,
  input  logic              cfg_sel,
  input  logic [EIDX_W-1:0] cfg_addr,
  input  logic [15:0]       cfg_wdata,
  input  logic [VIDX_W:0]   vert_count,
  input  logic [EIDX_W:0]   edge_count,
  input  logic              go,
  input  logic              abort,
  output logic [7:0]        x0,
  output logic [7:0]        y0,
  output logic [7:0]        x1,
  output logic [7:0]        y1,
  output logic              line_start,
  input  logic              line_done,
  output logic              busy,
  output logic              frame_done,
  output logic [EIDX_W-1:0] cur_edge,
  output logic              error
);

  localparam logic [EIDX_W:0]   EDGE_CAP = (EIDX_W+1)'(MAX_EDGES);
  localparam logic [EIDX_W:0]   ONE_CNT  = (EIDX_W+1)'(1);
  localparam logic [EIDX_W-1:0] EDGE_INC = EIDX_W'(1);

  seq_state_t      state;
  logic            fetch_ph;
  logic [EIDX_W:0] eff_cnt;
  logic [VIDX_W:0] vcnt;

  logic [15:0] edge_rd, vert_a_rd, vert_b_rd;
  edge_t       edge_p0;
  vertex_t     va_p1, vb_p1;

  logic [EIDX_W:0] go_cnt;
  logic            last_edge, bad_idx, zero_len;

  // Tables are frozen for the whole frame, FINISH included.
  wireframe_geom_ram #(
    .MAX_VERTS (MAX_VERTS),
    .MAX_EDGES (MAX_EDGES)
  ) u_geom_ram (
    .clk        (clk),
    .vert_we    (cfg_we && !busy && (cfg_sel == CFG_SEL_VERT)),
    .edge_we    (cfg_we && !busy && (cfg_sel == CFG_SEL_EDGE)),
    .waddr      (cfg_addr),
    .wdata      (cfg_wdata),
    .edge_raddr (cur_edge),
    .edge_rd    (edge_rd),
    .vert_a_rd  (vert_a_rd),
    .vert_b_rd  (vert_b_rd)
  );

  assign edge_p0 = edge_t'(edge_rd);
  assign va_p1   = vertex_t'(vert_a_rd);
  assign vb_p1   = vertex_t'(vert_b_rd);

  assign go_cnt    = (edge_count > EDGE_CAP) ? EDGE_CAP : edge_count;
  assign last_edge = (({1'b0, cur_edge} + ONE_CNT) >= eff_cnt);
  assign bad_idx   = ({8'h00, edge_p0.va} >= 16'(vcnt)) || ({8'h00, edge_p0.vb} >= 16'(vcnt));
  assign zero_len  = (va_p1 == vb_p1);

`ifdef SEQ_TIMEOUT_EN
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);
  logic [15:0] tmo_cnt;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      fetch_ph   <= 1'b0;
      eff_cnt    <= '0;
      vcnt       <= '0;
      cur_edge   <= '0;
      busy       <= 1'b0;
      line_start <= 1'b0;
      frame_done <= 1'b0;
      error      <= 1'b0;
      x0         <= '0;
      y0         <= '0;
      x1         <= '0;
      y1         <= '0;
`ifdef SEQ_TIMEOUT_EN
      tmo_cnt    <= '0;
`endif
    end else begin
      frame_done <= 1'b0;
      if (abort && (state != IDLE)) begin
        state      <= IDLE;
        line_start <= 1'b0;
        busy       <= 1'b0;
      end else begin
        case (state)
          IDLE: if (go) begin
            cur_edge <= '0;
            error    <= 1'b0;
            busy     <= 1'b1;
            eff_cnt  <= go_cnt;
            vcnt     <= vert_count;
            fetch_ph <= 1'b0;
            state    <= (go_cnt == '0) ? FINISH : FETCH;
          end
          FETCH: begin
            fetch_ph <= 1'b1;
            if (fetch_ph) state <= CHECK;
          end
          CHECK: begin
            if (bad_idx || zero_len) begin
              if (bad_idx) error <= 1'b1;
              if (last_edge) begin
                state <= FINISH;
              end else begin
                cur_edge <= cur_edge + EDGE_INC;
                fetch_ph <= 1'b0;
                state    <= FETCH;
              end
            end else begin
              x0         <= va_p1.x;
              y0         <= va_p1.y;
              x1         <= vb_p1.x;
              y1         <= vb_p1.y;
              line_start <= 1'b1;
              state      <= ISSUE;
            end
          end
          ISSUE: begin
            state <= WAIT_DONE;
`ifdef SEQ_TIMEOUT_EN
            tmo_cnt <= '0;
`endif
          end
          WAIT_DONE: begin
            if (line_done) begin
              line_start <= 1'b0;
              state      <= REARM;
            end
`ifdef SEQ_TIMEOUT_EN
            else if (tmo_cnt == TMO_LAST) begin
              error      <= 1'b1;
              line_start <= 1'b0;
              state      <= REARM;
            end else begin
              tmo_cnt <= tmo_cnt + 16'd1;
            end
`endif
          end
          REARM: begin
            if (last_edge) begin
              state <= FINISH;
            end else begin
              cur_edge <= cur_edge + EDGE_INC;
              fetch_ph <= 1'b0;
              state    <= FETCH;
            end
          end
          FINISH: begin
            frame_done <= 1'b1;
            busy       <= 1'b0;
            state      <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
